snake_gen: RTL

SNAKE_GEN -- requirements
Module: snake_gen

---
 rtl/snake_gen.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/snake_gen.sv
// snake_gen: snake game core on a 40x30 grid of 16x16 px cells.
// Occupancy lives in a 1200-bit cell bitmap for zero-latency pixel lookup, and
// a circular buffer holds the segment coordinates so the tail can be retired.
// Optional feature: define SNAKE_WRAP_EN to wrap the head around the grid edges
// instead of dying on a wall.
module snake_gen #(
    parameter int MOVE_DIV = 8,
    parameter int MAX_LEN  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_start,
    input  logic [3:0]  btn,
    input  logic        grow,
    output logic        snake_on,
    output logic [23:0] snake_color,
    output logic [5:0]  head_x,
    output logic [4:0]  head_y,
    output logic [6:0]  length,
    output logic        game_over
);
    // state   | meaning
    // S_IDLE  | initial snake shown, waiting for any button
    // S_RUN   | counting frames, stepping every MOVE_DIV frames
    // S_DEAD  | collision seen, snake frozen and drawn red
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
    // RIGHT/LEFT and UP/DOWN differ only in bit 0, so opposite = xor of 2'b01
    typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;

    localparam int NCELL = 1200;
    localparam int PW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int INIT_TAIL_IDX = 15 * 40 + 18;
    localparam logic [NCELL-1:0] INIT_BMP = {{(NCELL-3){1'b0}}, 3'b111} << INIT_TAIL_IDX;
    // buffer entries are {row[4:0], col[5:0]}
    localparam logic [10:0] CELL_T = {5'd15, 6'd18};
    localparam logic [10:0] CELL_B = {5'd15, 6'd19};
    localparam logic [10:0] CELL_H = {5'd15, 6'd20};

    function automatic logic [10:0] cell_idx(input logic [5:0] cx, input logic [4:0] cy);
        return ({6'd0, cy} * 11'd40) + {5'd0, cx};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + PW'(1);
    endfunction

    state_t            state_q, state_d;
    dir_t              dir_q, dir_d, pend_q, pend_d, req_dir;
    logic [5:0]        head_x_q, head_x_d, nx;
    logic [4:0]        head_y_q, head_y_d, ny;
    logic [6:0]        len_q, len_d;
    logic              grow_q, grow_d, step_q, step_d, go_q, go_d;
    logic [CW-1:0]     fcnt_q, fcnt_d;
    logic [PW-1:0]     hptr_q, hptr_d, tptr_q, tptr_d, hp_nxt;
    logic [NCELL-1:0]  bmp_q, bmp_d;
    logic [10:0]       cbuf_q [MAX_LEN];
    logic [10:0]       cbuf_d [MAX_LEN];
    logic [10:0]       tail_cell, tail_idx, next_idx, pix_idx;
    logic              wall, hit_wall, self_hit, collide, in_grid;

    // Candidate next head cell and collision tests for the pending direction
    always_comb begin
        wall = 1'b0;
        nx   = head_x_q;
        ny   = head_y_q;
        case (pend_q)
            D_RIGHT: if (head_x_q == 6'd39) begin wall = 1'b1; nx = 6'd0;  end else nx = head_x_q + 6'd1;
            D_LEFT:  if (head_x_q == 6'd0)  begin wall = 1'b1; nx = 6'd39; end else nx = head_x_q - 6'd1;
            D_UP:    if (head_y_q == 5'd0)  begin wall = 1'b1; ny = 5'd29; end else ny = head_y_q - 5'd1;
            default: if (head_y_q == 5'd29) begin wall = 1'b1; ny = 5'd0;  end else ny = head_y_q + 5'd1;
        endcase
`ifdef SNAKE_WRAP_EN
        hit_wall = 1'b0;
`else
        hit_wall = wall;
`endif
        tail_cell = cbuf_q[tptr_q];
        tail_idx  = cell_idx(tail_cell[5:0], tail_cell[10:6]);
        next_idx  = cell_idx(nx, ny);
        // the tail moves away this step unless growing, so it is not an obstacle
        self_hit  = bmp_q[next_idx] && !(({ny, nx} == tail_cell) && !grow_q);
        collide   = hit_wall || self_hit;
    end

`ifdef SNAKE_WRAP_EN
    logic unused_wall;
    assign unused_wall = wall;
`endif

    // Game state machine: direction decode, frame divider, step and reinit
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        len_d   = len_q;
        grow_d  = grow_q;
        step_d  = 1'b0;
        go_d    = go_q;
        fcnt_d  = fcnt_q;
        hptr_d  = hptr_q;
        tptr_d  = tptr_q;
        bmp_d   = bmp_q;
        cbuf_d  = cbuf_q;
        hp_nxt  = ptr_inc(hptr_q);

        if (btn[3])      req_dir = D_UP;
        else if (btn[2]) req_dir = D_DOWN;
        else if (btn[1]) req_dir = D_LEFT;
        else             req_dir = D_RIGHT;

        if ((|btn) && (state_q != S_DEAD) && ((2'(req_dir) ^ 2'(dir_q)) != 2'b01))
            pend_d = req_dir;

        case (state_q)
            S_IDLE: begin
                if (|btn) begin
                    state_d = S_RUN;
                    fcnt_d  = '0;
                    grow_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (frame_start) begin
                    if (fcnt_q == CW'(MOVE_DIV - 1)) begin
                        fcnt_d = '0;
                        step_d = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + CW'(1);
                    end
                end
                if (step_q) begin
                    if (collide) begin
                        state_d = S_DEAD;
                        go_d    = 1'b1;
                    end else begin
                        dir_d    = pend_q;
                        head_x_d = nx;
                        head_y_d = ny;
                        // retire the tail before setting the head: they may be the same cell
                        if (grow_q) begin
                            len_d = len_q + 7'd1;
                        end else begin
                            bmp_d[tail_idx] = 1'b0;
                            tptr_d = ptr_inc(tptr_q);
                        end
                        bmp_d[next_idx] = 1'b1;
                        cbuf_d[hp_nxt]  = {ny, nx};
                        hptr_d = hp_nxt;
                        grow_d = 1'b0;
                    end
                end
                if (grow && (len_d < 7'(MAX_LEN)))
                    grow_d = 1'b1;
            end
            default: begin
                if (|btn) begin
                    state_d  = S_IDLE;
                    go_d     = 1'b0;
                    dir_d    = D_RIGHT;
                    pend_d   = D_RIGHT;
                    head_x_d = 6'd20;
                    head_y_d = 5'd15;
                    len_d    = 7'd3;
                    grow_d   = 1'b0;
                    fcnt_d   = '0;
                    tptr_d   = '0;
                    hptr_d   = PW'(2);
                    bmp_d    = INIT_BMP;
                    cbuf_d[0] = CELL_T;
                    cbuf_d[1] = CELL_B;
                    cbuf_d[2] = CELL_H;
                end
            end
        endcase
    end

    // State registers with asynchronous reset to the initial snake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dir_q    <= D_RIGHT;
            pend_q   <= D_RIGHT;
            head_x_q <= 6'd20;
            head_y_q <= 5'd15;
            len_q    <= 7'd3;
            grow_q   <= 1'b0;
            step_q   <= 1'b0;
            go_q     <= 1'b0;
            fcnt_q   <= '0;
            tptr_q   <= '0;
            hptr_q   <= PW'(2);
            bmp_q    <= INIT_BMP;
            for (int i = 0; i < MAX_LEN; i++) cbuf_q[i] <= '0;
            cbuf_q[0] <= CELL_T;
            cbuf_q[1] <= CELL_B;
            cbuf_q[2] <= CELL_H;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            len_q    <= len_d;
            grow_q   <= grow_d;
            step_q   <= step_d;
            go_q     <= go_d;
            fcnt_q   <= fcnt_d;
            tptr_q   <= tptr_d;
            hptr_q   <= hptr_d;
            bmp_q    <= bmp_d;
            cbuf_q   <= cbuf_d;
        end
    end

    // Zero-latency pixel lookup against the occupancy bitmap
    always_comb begin
        in_grid = (x < 10'd640) && (y < 10'd480);
        pix_idx = '0;
        if (in_grid) pix_idx = cell_idx(x[9:4], y[8:4]);
        snake_on    = in_grid && bmp_q[pix_idx];
        snake_color = 24'h000000;
        if (snake_on) begin
            if (state_q == S_DEAD)
                snake_color = 24'hFF0000;
            else if ((x[9:4] == head_x_q) && (y[8:4] == head_y_q))
                snake_color = 24'h00FF00;
            else
                snake_color = 24'h008000;
        end
    end

    assign head_x    = head_x_q;
    assign head_y    = head_y_q;
    assign length    = len_q;
    assign game_over = go_q;

endmodule
